// File: rtl/gpi_sync_debounce_if.sv
// Bundle between the core and the GPI receiver: pad controls out, pad DI in,
// clean level and edge pulses back to the core.
interface gpi_sync_debounce_if #(
    parameter int CNT_W = 8
);
    logic             EN_I;
    logic [1:0]       STE_CFG_I;
    logic [CNT_W-1:0] DB_LEN_I;
    logic             PAD_DI_I;
    logic             PAD_IE_O;
    logic [1:0]       PAD_STE_O;
    logic             LEVEL_O;
    logic             VALID_O;
    logic             RISE_O;
    logic             FALL_O;

    modport master (
        output EN_I, STE_CFG_I, DB_LEN_I, PAD_DI_I,
        input  PAD_IE_O, PAD_STE_O, LEVEL_O, VALID_O, RISE_O, FALL_O
    );

    modport slave (
        input  EN_I, STE_CFG_I, DB_LEN_I, PAD_DI_I,
        output PAD_IE_O, PAD_STE_O, LEVEL_O, VALID_O, RISE_O, FALL_O
    );
endinterface

// File: rtl/gpi_sync_debounce.sv
// GPI pad receiver: drives IE/STE, synchronises DI, waits for the pad to settle,
// then debounces to a clean level with one-cycle rise/fall pulses.
module gpi_sync_debounce #(
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input logic                CLK_I,
    input logic                RST_I,
    gpi_sync_debounce_if.slave bus
);
    localparam int SCW = $clog2(SETTLE_CYCLES + 1);

    generate
        if (SYNC_STAGES < 2 || SETTLE_CYCLES < SYNC_STAGES + 1) begin : g_bad_param
            $error("gpi_sync_debounce: need SYNC_STAGES>=2 and SETTLE_CYCLES>=SYNC_STAGES+1");
        end
    endgenerate

    typedef enum logic [1:0] {OFF, SETTLE, TRACK} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_chain_q, sync_chain_d;
    logic [SCW-1:0]         settle_cnt_q, settle_cnt_d;
    logic [CNT_W-1:0]       db_cnt_q, db_cnt_d;
    logic [1:0]             ste_q, ste_d;
    logic                   ie_q, ie_d;
    logic                   level_q, level_d;
    logic                   valid_q, valid_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   sync_q;
    logic                   go_off;
    logic [CNT_W:0]         db_len_eff;
    logic [CNT_W:0]         db_next;

    assign sync_q = sync_chain_q[SYNC_STAGES-1];

    // One extra bit so db_cnt+1 against the length never overflows.
    assign db_len_eff = (bus.DB_LEN_I == '0) ? (CNT_W+1)'(1) : {1'b0, bus.DB_LEN_I};
    assign db_next    = {1'b0, db_cnt_q} + (CNT_W+1)'(1);

    always_comb begin
        state_d      = state_q;
        sync_chain_d = {sync_chain_q[SYNC_STAGES-2:0], bus.PAD_DI_I};
        settle_cnt_d = settle_cnt_q;
        db_cnt_d     = db_cnt_q;
        ste_d        = bus.STE_CFG_I;
        ie_d         = ie_q;
        level_d      = level_q;
        valid_d      = valid_q;
        rise_d       = 1'b0;
        fall_d       = 1'b0;
        go_off       = 1'b0;
        case (state_q)
            OFF: begin
                if (bus.EN_I) begin
                    state_d      = SETTLE;
                    ie_d         = 1'b1;
                    settle_cnt_d = '0;
                end
            end
            SETTLE: begin
                if (!bus.EN_I) begin
                    go_off = 1'b1;
                end else if (settle_cnt_q == SCW'(SETTLE_CYCLES - 1)) begin
                    // Adopt the current level silently; no edge is reported on entry.
                    state_d  = TRACK;
                    level_d  = sync_q;
                    valid_d  = 1'b1;
                    db_cnt_d = '0;
                end else begin
                    settle_cnt_d = settle_cnt_q + SCW'(1);
                end
            end
            TRACK: begin
                if (!bus.EN_I) begin
                    go_off = 1'b1;
                end else if (sync_q == level_q) begin
                    db_cnt_d = '0;
                end else if (db_next >= db_len_eff) begin
                    level_d  = sync_q;
                    db_cnt_d = '0;
                    rise_d   = sync_q;
                    fall_d   = ~sync_q;
                end else begin
                    db_cnt_d = db_next[CNT_W-1:0];
                end
            end
            default: go_off = 1'b1;
        endcase
        if (go_off) begin
            state_d      = OFF;
            ie_d         = 1'b0;
            valid_d      = 1'b0;
            level_d      = 1'b0;
            settle_cnt_d = '0;
            db_cnt_d     = '0;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q      <= OFF;
            sync_chain_q <= '0;
            settle_cnt_q <= '0;
            db_cnt_q     <= '0;
            ste_q        <= 2'b00;
            ie_q         <= 1'b0;
            level_q      <= 1'b0;
            valid_q      <= 1'b0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_chain_q <= sync_chain_d;
            settle_cnt_q <= settle_cnt_d;
            db_cnt_q     <= db_cnt_d;
            ste_q        <= ste_d;
            ie_q         <= ie_d;
            level_q      <= level_d;
            valid_q      <= valid_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
        end
    end

    assign bus.PAD_IE_O  = ie_q;
    assign bus.PAD_STE_O = ste_q;
    assign bus.LEVEL_O   = level_q;
    assign bus.VALID_O   = valid_q;
    assign bus.RISE_O    = rise_q;
    assign bus.FALL_O    = fall_q;
endmodule

// File: tb/tb_gpi_sync_debounce.sv
// Random and directed pad/enable traffic; a history-based reference model
// queues the expected outputs of every cycle and a monitor checks them.
module tb_gpi_sync_debounce;
    localparam int SYNC   = 2;
    localparam int SETTLE = 4;
    localparam int CNT_W  = 8;

    typedef struct packed {
        logic       ie;
        logic [1:0] ste;
        logic       level;
        logic       valid;
        logic       rise;
        logic       fall;
    } out_t;

    logic clk;
    logic rst;
    gpi_sync_debounce_if #(.CNT_W(CNT_W)) bus();

    gpi_sync_debounce #(
        .SYNC_STAGES  (SYNC),
        .SETTLE_CYCLES(SETTLE),
        .CNT_W        (CNT_W)
    ) dut (
        .CLK_I(clk),
        .RST_I(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    out_t exp_q[$];

    bit       cur_rst, cur_en, cur_pad;
    bit [1:0] cur_ste;
    int       cur_len;

    // Reference state: raw pad samples in flight, consecutive enabled edges,
    // and the run of synchronised samples in TRACK that disagree with the level.
    bit m_hist[$];
    int m_en_cyc;
    bit m_level;
    bit m_disagree[$];

    task automatic model_step();
        out_t e;
        bit   sync_b;
        int   prev;
        int   need;
        e = '0;
        if (cur_rst) begin
            m_hist.delete();
            repeat (SYNC) m_hist.push_back(1'b0);
            m_en_cyc = 0;
            m_level  = 1'b0;
            m_disagree.delete();
        end else begin
            sync_b = m_hist[0];
            e.ste  = cur_ste;
            if (!cur_en) begin
                m_en_cyc = 0;
                m_level  = 1'b0;
                m_disagree.delete();
            end else begin
                prev = m_en_cyc;
                if (m_en_cyc <= SETTLE) m_en_cyc++;
                if (prev == SETTLE) begin
                    m_level = sync_b;
                    m_disagree.delete();
                end else if (prev > SETTLE) begin
                    need = (cur_len == 0) ? 1 : cur_len;
                    if (sync_b == m_level) m_disagree.delete();
                    else m_disagree.push_back(sync_b);
                    if (m_disagree.size() >= need) begin
                        m_level = sync_b;
                        e.rise  = sync_b;
                        e.fall  = !sync_b;
                        m_disagree.delete();
                    end
                end
            end
            m_hist.push_back(cur_pad);
            void'(m_hist.pop_front());
        end
        e.ie    = (m_en_cyc >= 1);
        e.valid = (m_en_cyc >= SETTLE + 1);
        e.level = m_level;
        exp_q.push_back(e);
    endtask

    task automatic drive_now();
        rst           = cur_rst;
        bus.EN_I      = cur_en;
        bus.STE_CFG_I = cur_ste;
        bus.DB_LEN_I  = CNT_W'(cur_len);
        bus.PAD_DI_I  = cur_pad;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            drive_now();
            model_step();
        end
    endtask

    // Monitor: every posedge the DUT presents a full output set.
    int mon_cyc = 0;
    initial begin
        out_t got;
        out_t e;
        forever begin
            @(posedge clk);
            #1;
            mon_cyc++;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {bus.PAD_IE_O, bus.PAD_STE_O, bus.LEVEL_O, bus.VALID_O, bus.RISE_O, bus.FALL_O};
                checks++;
                if (got !== e) begin
                    failures++;
                    $display("FAIL outputs cyc=%0d {ie,ste,level,valid,rise,fall} got=%b exp=%b",
                             mon_cyc, got, e);
                end
            end
        end
    end

    initial begin
        cur_rst = 1'b1; cur_en = 1'b1; cur_pad = 1'b1; cur_ste = 2'b00; cur_len = 5;
        repeat (SYNC) m_hist.push_back(1'b0);
        m_en_cyc = 0;
        m_level  = 1'b0;
        drive_now();

        // Reset held with EN and DI high, then release into SETTLE/TRACK at level 1.
        run(3);
        cur_rst = 1'b0;
        run(8);

        // Debounced fall, rise, fall at length 5.
        cur_pad = 1'b0; run(12);
        cur_pad = 1'b1; run(10);
        cur_pad = 1'b0; run(10);

        // Glitch of 4 cycles is filtered; length 0 lets a 1-cycle pulse through.
        cur_pad = 1'b1; run(4);
        cur_pad = 1'b0; run(10);
        cur_len = 0;
        cur_pad = 1'b1; run(1);
        cur_pad = 1'b0; run(6);

        // Disable while level is 1 and a fall is mid-debounce, then re-enable.
        cur_len = 5;
        cur_pad = 1'b1; run(10);
        cur_pad = 1'b0; run(3);
        cur_en  = 1'b0; run(2);
        cur_en  = 1'b1; run(10);

        // STE follows in every state.
        cur_ste = 2'b10; run(2);
        cur_en  = 1'b0;  run(2);
        cur_ste = 2'b01; run(1);
        cur_en  = 1'b1;  run(8);

        // Long length, then shrink it below the running count.
        cur_len = 200;
        cur_pad = 1'b1; run(13);
        cur_len = 3;    run(4);

        // Reset mid-SETTLE and mid-TRACK with EN held high.
        cur_en  = 1'b0; run(1);
        cur_en  = 1'b1; run(2);
        cur_rst = 1'b1; run(1);
        cur_rst = 1'b0; run(8);
        cur_rst = 1'b1; run(1);
        cur_rst = 1'b0; run(10);

        // Randomised traffic.
        for (int i = 0; i < 350; i++) begin
            cur_pad = 1'($urandom_range(0, 1));
            cur_len = int'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) cur_ste = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) cur_en = ~cur_en;
            else if (!cur_en && $urandom_range(0, 2) == 0) cur_en = 1'b1;
            cur_rst = ($urandom_range(0, 59) == 0);
            run(int'($urandom_range(1, 12)));
            cur_rst = 1'b0;
        end

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain leftover=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
